// File: rtl/elem_neg_seq_if.sv
// Clock/reset bundle for the sequenced fixed-point element blocks.
// WIDTH records the element width of the datapath attached to this bundle.
interface fixedp #(
    parameter int WIDTH = 16
);
    typedef logic [WIDTH-1:0] elem_t;

    logic clk;
    logic reset;

    modport master (output clk, output reset);
    modport slave  (input  clk, input  reset);
endinterface

// File: rtl/elem_neg_seq.sv
// Element-wise negate of a ROWS x COLS matrix, walked row-major LANES elements
// per cycle through a shared bank of negate lanes under a start/busy/done controller.
module elem_neg_seq #(
    parameter int ROWS  = 1,
    parameter int COLS  = 1,
    parameter int LANES = 1,
    parameter int WIDTH = 16
) (
    fixedp.slave                              g,
    input  logic                              start,
    input  logic [ROWS:1][COLS:1][WIDTH-1:0]  a,
    output logic [ROWS:1][COLS:1][WIDTH-1:0]  f,
    output logic                              busy,
    output logic                              done
);
    localparam int TOTAL = ROWS * COLS;
    localparam int BEATS = (TOTAL + LANES - 1) / LANES;
    localparam int BW    = $clog2(BEATS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Two's-complement negate at WIDTH bits; the most negative value maps to itself.
    function automatic logic signed [WIDTH-1:0] neg(input logic signed [WIDTH-1:0] x);
        return -x;
    endfunction

    state_t                       state;
    logic [BW-1:0]                beat;
    logic [TOTAL-1:0][WIDTH-1:0]  opnd_p0;
    logic [TOTAL-1:0][WIDTH-1:0]  f_p1;
    logic signed [WIDTH-1:0]      lane_in  [LANES];
    logic signed [WIDTH-1:0]      lane_out [LANES];

    // Stage p0 -> lanes: route element k to lane k%LANES during beat k/LANES.
    always_comb begin
        for (int j = 0; j < LANES; j++) lane_in[j] = '0;
        for (int k = 0; k < TOTAL; k++) begin
            if (beat == BW'(k / LANES)) lane_in[k % LANES] = opnd_p0[k];
        end
        for (int j = 0; j < LANES; j++) lane_out[j] = neg(lane_in[j]);
    end

    // Stage lanes -> p1: write back the beat's elements; controller advances.
    always_ff @(posedge g.clk) begin
        if (g.reset) begin
            state   <= S_IDLE;
            beat    <= '0;
            opnd_p0 <= '0;
            f_p1    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opnd_p0 <= a;
                        beat    <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < TOTAL; k++) begin
                        if (beat == BW'(k / LANES)) f_p1[k] <= lane_out[k % LANES];
                    end
                    if (beat == BW'(BEATS - 1)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        beat <= beat + BW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign f = f_p1;

endmodule

// File: tb/tb_elem_neg_seq.sv
// Scoreboard bench for elem_neg_seq: three configurations (2x3/1 lane, 2x3/4 lanes, 2x2/4 lanes)
// share one clock/reset bundle; a monitor pops expected results whenever done is seen.
module tb_elem_neg_seq;
    localparam int W = 16;

    typedef struct packed {
        logic [95:0] f;
        int          cyc;
    } exp_t;

    localparam logic [95:0] A0 = {16'h0001, 16'h7FFF, 16'h0000, 16'hFF00, 16'h0200, 16'h0100};
    localparam logic [95:0] F0 = {16'hFFFF, 16'h8001, 16'h0000, 16'h0100, 16'hFE00, 16'hFF00};
    localparam logic [95:0] A1 = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
    localparam logic [95:0] A2 = {16'hAAAA, 16'h8000, 16'h0FF0, 16'hC001, 16'h00FF, 16'h7FFE};
    localparam logic [95:0] A3 = {16'h0003, 16'h0030, 16'h0300, 16'h3000, 16'hFFFD, 16'h8001};
    localparam logic [95:0] A4 = {16'h4000, 16'hBFFF, 16'h0101, 16'hFEFE, 16'h00A5, 16'h5A00};
    localparam logic [95:0] A5 = {16'h0042, 16'h1000, 16'hF000, 16'h0007, 16'hDEAD, 16'hBEEF};

    fixedp #(.WIDTH(W)) g ();

    logic startA, busyA, doneA;
    logic startB, busyB, doneB;
    logic startC, busyC, doneC;
    logic [2:1][3:1][W-1:0] aA, fA, aB, fB;
    logic [2:1][2:1][W-1:0] aC, fC;

    elem_neg_seq #(.ROWS(2), .COLS(3), .LANES(1), .WIDTH(W)) u_a (
        .g(g), .start(startA), .a(aA), .f(fA), .busy(busyA), .done(doneA));
    elem_neg_seq #(.ROWS(2), .COLS(3), .LANES(4), .WIDTH(W)) u_b (
        .g(g), .start(startB), .a(aB), .f(fB), .busy(busyB), .done(doneB));
    elem_neg_seq #(.ROWS(2), .COLS(2), .LANES(4), .WIDTH(W)) u_c (
        .g(g), .start(startC), .a(aC), .f(fC), .busy(busyC), .done(doneC));

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qA[$];
    exp_t qB[$];
    exp_t qC[$];

    initial g.clk = 1'b0;
    always #5 g.clk = ~g.clk;
    always @(posedge g.clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [95:0] negm(input logic [95:0] x, input int n);
        logic [95:0] r = '0;
        for (int i = 0; i < n; i++) r[i*16 +: 16] = (~x[i*16 +: 16]) + 16'd1;
        return r;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? busyA : (sel == 1) ? busyB : busyC;
    endfunction

    task automatic tick();
        @(posedge g.clk);
        #1;
    endtask

    task automatic wait_idle(input int sel, input string name);
        int n = 0;
        while (busy_of(sel) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
        end
    endtask

    // The value seen at a negedge is sampled at the following rising edge, cycle cyc+1.
    always @(negedge g.clk) begin
        exp_t e;
        if (doneA) begin
            if (qA.size() == 0) begin
                checks++; errors++;
                $display("FAIL A_spurious_done: done=1 at cycle %0d, expected no done", cyc + 1);
            end else begin
                e = qA.pop_front();
                check("A_f", 96'(fA), e.f);
                check_int("A_done_cycle", cyc + 1, e.cyc);
            end
        end
        if (doneB) begin
            if (qB.size() == 0) begin
                checks++; errors++;
                $display("FAIL B_spurious_done: done=1 at cycle %0d, expected no done", cyc + 1);
            end else begin
                e = qB.pop_front();
                check("B_f", 96'(fB), e.f);
                check_int("B_done_cycle", cyc + 1, e.cyc);
            end
        end
        if (doneC) begin
            if (qC.size() == 0) begin
                checks++; errors++;
                $display("FAIL C_spurious_done: done=1 at cycle %0d, expected no done", cyc + 1);
            end else begin
                e = qC.pop_front();
                check("C_f", {32'd0, fC}, e.f);
                check_int("C_done_cycle", cyc + 1, e.cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          t;
        int          n;
        logic [95:0] nA5;
        logic [95:0] cv;
        nA5    = negm(A5, 6);
        g.reset = 1'b1;
        startA = 1'b0; startB = 1'b0; startC = 1'b0;
        aA = '0; aB = '0; aC = '0;
        repeat (3) tick();
        check("reset_ctrl", 96'({busyA, doneA, busyB, doneB, busyC, doneC}), 96'd0);
        check("reset_fA", 96'(fA), 96'd0);
        check("reset_fB", 96'(fB), 96'd0);
        check("reset_fC", {32'd0, fC}, 96'd0);
        g.reset = 1'b0;
        tick();

        // Basic run, one element per beat.
        aA = A0; startA = 1'b1; tick(); t = cyc; startA = 1'b0;
        qA.push_back(exp_t'{F0, t + 7});
        check("A_busy_T1", 96'(busyA), 96'd1);
        check("A_f_hold", 96'(fA), 96'd0);
        tick();
        check("A_beat0", 96'(fA), {80'd0, 16'hFF00});
        check("A_no_early_done", 96'(doneA), 96'd0);
        wait_idle(0, "A_basic");
        check("A_basic_stable", 96'(fA), F0);

        // Starts during RUN and during DONE are ignored; a changes after the start edge.
        aA = A1; startA = 1'b1; tick(); t = cyc; startA = 1'b0;
        qA.push_back(exp_t'{negm(A1, 6), t + 7});
        aA = A2; tick();
        startA = 1'b1; tick(); startA = 1'b0;
        n = 0;
        while (!doneA && n < 20) begin tick(); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL A_ign_done_timeout: no done after %0d cycles, expected done", n);
        end
        startA = 1'b1; tick(); startA = 1'b0;
        check("A_ign_busy", 96'(busyA), 96'd0);
        repeat (10) tick();
        check("A_ign_still_idle", 96'(busyA), 96'd0);
        check("A_ign_f", 96'(fA), negm(A1, 6));

        // Back-to-back with start held high.
        aA = A3; startA = 1'b1; tick(); t = cyc;
        qA.push_back(exp_t'{negm(A3, 6), t + 7});
        qA.push_back(exp_t'{negm(A4, 6), t + 15});
        aA = A4;
        repeat (8) tick();
        startA = 1'b0; aA = A0;
        check("A_b2b_busy", 96'(busyA), 96'd1);
        wait_idle(0, "A_b2b");
        check("A_b2b_f", 96'(fA), negm(A4, 6));

        // Reset in the middle of a run aborts it.
        aA = A0; startA = 1'b1; tick(); startA = 1'b0;
        tick(); tick();
        g.reset = 1'b1; tick(); g.reset = 1'b0;
        check("A_rst_ctrl", 96'({busyA, doneA}), 96'd0);
        check("A_rst_f", 96'(fA), 96'd0);
        repeat (10) tick();
        check("A_rst_idle", 96'(busyA), 96'd0);
        aA = A2; startA = 1'b1; tick(); t = cyc; startA = 1'b0;
        qA.push_back(exp_t'{negm(A2, 6), t + 7});
        wait_idle(0, "A_after_rst");
        check("A_after_rst_f", 96'(fA), negm(A2, 6));

        // Partial final beat: 4 lanes over 6 elements.
        aB = A5; startB = 1'b1; tick(); t = cyc; startB = 1'b0;
        qB.push_back(exp_t'{nA5, t + 3});
        wait_idle(1, "B_first");
        check("B_first_f", 96'(fB), nA5);
        aB = A0; startB = 1'b1; tick(); t = cyc; startB = 1'b0;
        qB.push_back(exp_t'{F0, t + 3});
        check("B_hold", 96'(fB), nA5);
        tick();
        check("B_beat0", 96'(fB), {nA5[95:64], F0[63:0]});
        wait_idle(1, "B_second");
        check("B_final", 96'(fB), F0);

        // Full-parallel: one beat per run, a new run every three cycles.
        for (int r = 0; r < 1000; r++) begin
            if (r == 0)      cv = {32'd0, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
            else if (r == 1) cv = {32'd0, 16'h0001, 16'h8001, 16'hFFFE, 16'h1234};
            else             cv = {32'd0, $urandom(), $urandom()};
            aC = cv[63:0]; startC = 1'b1; tick(); t = cyc; startC = 1'b0;
            qC.push_back(exp_t'{negm(cv, 4), t + 2});
            aC = ~cv[63:0];
            tick(); tick();
            if (r == 0) check("C_edges", {32'd0, fC}, {32'd0, 16'h8000, 16'h8001, 16'h0000, 16'h0001});
        end

        repeat (5) tick();
        check_int("A_pending", qA.size(), 0);
        check_int("B_pending", qB.size(), 0);
        check_int("C_pending", qC.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
